// File: rtl/trace_fetch_pkg.sv
// Shared types and constants for the trace fetch sequencer.
// Sample geometry, memory map and the fetch FSM encoding.
package trace_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      SWAP
   } state_e;

   localparam int SAMPLES    = 320;
   localparam int ADDR_W     = 12;
   localparam int DATA_W     = 32;
   localparam int IDX_W      = 9;
   localparam int CNT_W      = 10;
   localparam int SAMPLE_MSB = 11;
   localparam int SAMPLE_LSB = 4;

   localparam logic [ADDR_W-1:0] CH0_BASE = 12'h559;
   localparam logic [ADDR_W-1:0] CH1_BASE = 12'h6AD;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SAMPLES - 1);
   localparam logic [CNT_W-1:0] SAMPLES_N = CNT_W'(SAMPLES);
   localparam logic [CNT_W-1:0] LAST_N    = CNT_W'(2 * SAMPLES - 1);

endpackage

// File: rtl/trace_sample_ram.sv
// Double-banked two-channel sample store.
// One synchronous write port, one registered read port.
module trace_sample_ram
   import trace_fetch_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic             wr_bank,
   input  logic             wr_ch,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [7:0]       wr_data,
   input  logic             rd_bank,
   input  logic             rd_ch,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [7:0]       rd_data
);

   logic [7:0] mem_q [2][2][SAMPLES];
   logic [7:0] rd_data_q, rd_data_d;

   always_ff @(posedge clock) begin
      if (wr_en && (wr_idx <= LAST_IDX)) begin
         mem_q[wr_bank][wr_ch][wr_idx] <= wr_data;
      end
   end

   // Indices past the last sample read as zero.
   always_comb begin
      rd_data_d = '0;
      if (rd_idx <= LAST_IDX) begin
         rd_data_d = mem_q[rd_bank][rd_ch][rd_idx];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/trace_fetch_sequencer.sv
// Per-frame fetch of two sample channels from shared memory
// into a double-banked buffer read by the trace renderer.
module trace_fetch_sequencer
   import trace_fetch_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              frame_start,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              rd_ch,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [7:0]        rd_sample,
   output logic              busy,
   output logic              frame_done,
   output logic              overrun
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic             ret_vld_q, ret_vld_d;
   logic             ret_ch_q, ret_ch_d;
   logic [IDX_W-1:0] ret_idx_q, ret_idx_d;
   logic             disp_bank_q, disp_bank_d;
   logic             overrun_q, overrun_d;

   logic             accept;
   logic             cur_ch;
   logic [IDX_W-1:0] cur_idx;
   logic             unused_rdata;

   assign unused_rdata = ^{mem_rdata[DATA_W-1:SAMPLE_MSB+1],
                           mem_rdata[SAMPLE_LSB-1:0]};

   // Issue counter splits into channel and sample index.
   always_comb begin
      cur_ch  = (n_q >= SAMPLES_N);
      cur_idx = cur_ch ? IDX_W'(n_q - SAMPLES_N) : IDX_W'(n_q);
   end

   always_comb begin
      mem_req  = (state_q == FETCH);
      mem_addr = '0;
      if (mem_req) begin
         mem_addr = (cur_ch ? CH1_BASE : CH0_BASE)
                  + ADDR_W'(cur_idx);
      end
      accept     = mem_req & mem_gnt;
      busy       = (state_q != IDLE);
      frame_done = (state_q == SWAP);
   end

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      disp_bank_d = disp_bank_q;
      overrun_d   = overrun_q | (frame_start & busy);
      ret_vld_d   = accept;
      ret_ch_d    = ret_ch_q;
      ret_idx_d   = ret_idx_q;
      if (accept) begin
         ret_ch_d  = cur_ch;
         ret_idx_d = cur_idx;
      end
      unique case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d = FETCH;
               n_d     = '0;
            end
         end
         FETCH: begin
            if (accept) begin
               n_d = n_q + 1'b1;
               if (n_q == LAST_N) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            state_d = SWAP;
         end
         SWAP: begin
            disp_bank_d = ~disp_bank_q;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         n_q         <= '0;
         ret_vld_q   <= 1'b0;
         ret_ch_q    <= 1'b0;
         ret_idx_q   <= '0;
         disp_bank_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         ret_vld_q   <= ret_vld_d;
         ret_ch_q    <= ret_ch_d;
         ret_idx_q   <= ret_idx_d;
         disp_bank_q <= disp_bank_d;
         overrun_q   <= overrun_d;
      end
   end

   assign overrun = overrun_q;

   // Returns always land in the bank not on display.
   trace_sample_ram u_ram (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (ret_vld_q),
      .wr_bank (~disp_bank_q),
      .wr_ch   (ret_ch_q),
      .wr_idx  (ret_idx_q),
      .wr_data (mem_rdata[SAMPLE_MSB:SAMPLE_LSB]),
      .rd_bank (disp_bank_q),
      .rd_ch   (rd_ch),
      .rd_idx  (rd_idx),
      .rd_data (rd_sample)
   );

endmodule

// File: tb/tb_trace_fetch_sequencer.sv
// Bench for trace_fetch_sequencer: address scoreboard,
// read-back tables and multi-cycle corner sequences.
module tb_trace_fetch_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        frame_start;
   logic        mem_req;
   logic        mem_gnt;
   logic [11:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        rd_ch;
   logic [8:0]  rd_idx;
   logic [7:0]  rd_sample;
   logic        busy;
   logic        frame_done;
   logic        overrun;

   trace_fetch_sequencer dut (
      .clock       (clock),
      .reset       (reset),
      .frame_start (frame_start),
      .mem_req     (mem_req),
      .mem_gnt     (mem_gnt),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .rd_ch       (rd_ch),
      .rd_idx      (rd_idx),
      .rd_sample   (rd_sample),
      .busy        (busy),
      .frame_done  (frame_done),
      .overrun     (overrun)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       ch;
      logic [8:0] idx;
      logic [7:0] exp;
   } rd_vec_t;

   int          cyc = 0;
   int          t0 = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          acc_cnt = 0;
   logic [11:0] exp_q[$];
   bit          pend = 0;
   logic [31:0] pend_data = '0;
   logic [7:0]  key = '0;
   bit          gnt_rand = 0;
   bit          prev_stall = 0;
   logic [11:0] prev_addr = '0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (cyc %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mk_data(input logic [11:0] a,
                                           input logic [7:0] k);
      return {16'hA5A5, a[11:8], a[7:0] ^ k, 4'hF};
   endfunction

   function automatic logic [7:0] exp_samp(input bit ch, input int idx,
                                           input logic [7:0] k);
      logic [11:0] a;
      a = (ch ? 12'h6AD : 12'h559) + 12'(idx);
      return a[7:0] ^ k;
   endfunction

   // Accept monitor: pops the expected address per accepted read.
   always @(negedge clock) begin
      if (reset && mem_req) begin
         if (prev_stall) chk("addr_hold", mem_addr, prev_addr);
         prev_stall = !mem_gnt;
         prev_addr  = mem_addr;
      end else begin
         prev_stall = 0;
      end
      pend = 0;
      if (reset && mem_req && mem_gnt) begin
         acc_cnt++;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexp_accept: got addr %h, required none",
                     mem_addr);
         end else begin
            chk("addr", mem_addr, exp_q.pop_front());
         end
         pend      = 1;
         pend_data = mk_data(mem_addr, key);
      end
   end

   // Memory model: data one cycle after acceptance, grant source.
   always @(posedge clock) begin
      #1;
      mem_rdata = pend ? pend_data : 32'hDEAD_BEEF;
      mem_gnt   = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic pulse_start();
      for (int n = 0; n < 640; n++) begin
         exp_q.push_back(n < 320 ? 12'h559 + 12'(n)
                                 : 12'h6AD + 12'(n - 320));
      end
      frame_start = 1'b1;
      t0 = cyc;
      @(posedge clock); #1;
      frame_start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clock); #1;
         if (frame_done) begin
            lat = cyc - t0;
            break;
         end
      end
      if (lat < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL frame_done_timeout: got none, required pulse");
      end
   endtask

   task automatic rd(input logic ch, input logic [8:0] idx,
                     output logic [7:0] v);
      rd_ch  = ch;
      rd_idx = idx;
      @(posedge clock); #1;
      v = rd_sample;
   endtask

   task automatic check_bank(input string nm, input logic [7:0] k);
      logic [7:0] v;
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < 320; i++) begin
            rd(c[0], 9'(i), v);
            chk(nm, {c[7:0], 7'(i), v}, {c[7:0], 7'(i), exp_samp(c[0], i, k)});
         end
      end
   endtask

   task automatic frame_end_checks(input string nm);
      chk({nm, "_accepts"}, acc_cnt, 640);
      chk({nm, "_q_empty"}, exp_q.size(), 0);
      chk({nm, "_busy_low"}, busy, 1'b0);
   endtask

   rd_vec_t tbl[11];

   initial begin
      int         lat;
      logic [7:0] v;

      tbl[0]  = '{1'b0, 9'd0,   8'h59};
      tbl[1]  = '{1'b0, 9'd10,  8'h63};
      tbl[2]  = '{1'b0, 9'd319, 8'h98};
      tbl[3]  = '{1'b1, 9'd0,   8'hAD};
      tbl[4]  = '{1'b1, 9'd100, 8'h11};
      tbl[5]  = '{1'b1, 9'd319, 8'hEC};
      tbl[6]  = '{1'b0, 9'd320, 8'h00};
      tbl[7]  = '{1'b0, 9'd511, 8'h00};
      tbl[8]  = '{1'b1, 9'd320, 8'h00};
      tbl[9]  = '{1'b1, 9'd511, 8'h00};
      tbl[10] = '{1'b1, 9'd1,   8'hAE};

      reset = 1'b0;
      frame_start = 1'b0;
      rd_ch = 1'b0;
      rd_idx = '0;
      mem_rdata = '0;
      mem_gnt = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_addr", mem_addr, 12'h000);
      chk("rst_rd_sample", rd_sample, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      reset = 1'b1;
      @(posedge clock); #1;

      // Frame 1: grant held high.
      key = 8'h00;
      acc_cnt = 0;
      pulse_start();
      chk("f1_busy", busy, 1'b1);
      wait_done(lat);
      chk("f1_latency", lat, 642);
      @(posedge clock); #1;
      frame_end_checks("f1");
      for (int i = 0; i < 11; i++) begin
         rd(tbl[i].ch, tbl[i].idx, v);
         chk($sformatf("tbl%0d", i), v, tbl[i].exp);
      end

      // Frame 2: random grant, same data.
      gnt_rand = 1;
      acc_cnt = 0;
      pulse_start();
      wait_done(lat);
      gnt_rand = 0;
      @(posedge clock); #1;
      frame_end_checks("f2");
      check_bank("f2_data", 8'h00);

      // Frame 3: display stable until the swap.
      key = 8'h3C;
      acc_cnt = 0;
      rd_ch = 1'b0;
      rd_idx = 9'd10;
      pulse_start();
      while (cyc - t0 < 644) begin
         if (cyc - t0 <= 643)
            chk("f3_hold_old", rd_sample, 8'h63);
         chk("f3_done_timing", frame_done, (cyc - t0) == 642);
         @(posedge clock); #1;
      end
      chk("f3_new", rd_sample, 8'h5F);
      frame_end_checks("f3");

      // Frame 4: frame_start while busy.
      key = 8'hC3;
      acc_cnt = 0;
      pulse_start();
      while (cyc - t0 < 300) begin
         @(posedge clock); #1;
      end
      chk("f4_overrun_pre", overrun, 1'b0);
      frame_start = 1'b1;
      @(posedge clock); #1;
      frame_start = 1'b0;
      chk("f4_overrun_set", overrun, 1'b1);
      wait_done(lat);
      chk("f4_latency", lat, 642);
      repeat (20) @(posedge clock);
      #1;
      frame_end_checks("f4");
      chk("f4_overrun_sticky", overrun, 1'b1);

      // Frame 5: reset in the middle of the fetch.
      key = 8'h77;
      pulse_start();
      while (cyc - t0 < 200) begin
         @(posedge clock); #1;
      end
      #1;
      reset = 1'b0;
      #1;
      chk("f5_req_async", mem_req, 1'b0);
      chk("f5_busy_async", busy, 1'b0);
      exp_q.delete();
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      chk("f5_overrun_clr", overrun, 1'b0);
      check_bank("f5_keep", 8'hC3);

      // Frame 6: full fetch, frame_start during SWAP.
      key = 8'h5A;
      acc_cnt = 0;
      pulse_start();
      while (cyc - t0 < 642) begin
         @(posedge clock); #1;
      end
      chk("f6_done", frame_done, 1'b1);
      frame_start = 1'b1;
      @(posedge clock); #1;
      frame_start = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      chk("f6_overrun", overrun, 1'b1);
      frame_end_checks("f6");
      check_bank("f6_data", 8'h5A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/trace_fetch_sequencer.md
Name: trace_fetch_sequencer

Overview:
- Fetches one frame of signal samples per video frame from the shared signal memory, for two channels (ECG, EMG) of SAMPLES points each.
- Stores the samples in a double-banked local buffer so the VGA renderer gets stable per-pixel samples with fixed latency.
- Reaches the shared memory through a req/gnt port on the signal memory arbiter, which it shares with the CPU.
- Sits between the signal memory arbiter and the VGA trace renderer.

Parameters:
- SAMPLES, 320, samples per channel per frame.
- CH0_BASE, 12'h559, word address of channel 0 sample 0.
- CH1_BASE, 12'h6AD, word address of channel 1 sample 0.
- ADDR_W, 12, memory address width.
- DATA_W, 32, memory data width.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at screen end, already synchronised to clock.
- mem_req  out  1  memory read request.
- mem_gnt  in  1  arbiter grant; a read is accepted in any cycle with mem_req&mem_gnt.
- mem_addr  out  ADDR_W  read address; valid while mem_req=1.
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after acceptance.
- rd_ch  in  1  renderer channel select.
- rd_idx  in  9  renderer sample index.
- rd_sample  out  8  registered sample from the display bank.
- busy  out  1  high from FETCH entry until SWAP completes.
- frame_done  out  1  one-cycle pulse on bank swap.
- overrun  out  1  sticky; set when frame_start arrives while busy.

Behaviour:
- Reset values: mem_req=0, mem_addr=0, rd_sample=0, busy=0, frame_done=0, overrun=0. Display bank=0, write bank=1, FSM=IDLE, counters=0, buffer contents undefined.
- FSM states: IDLE, FETCH, DRAIN, SWAP.
- IDLE: on frame_start -> FETCH next cycle; clear the issue counter.
- FETCH:
  - mem_req=1.
  - Issue counter n runs 0..2*SAMPLES-1.
  - mem_addr = CH0_BASE+n for n<SAMPLES, else CH1_BASE+(n-SAMPLES). Computed modulo 2^ADDR_W.
  - On acceptance, n increments and {ch,idx} is pushed into a one-deep return register with a valid flag.
  - When the accepted request is n=2*SAMPLES-1 -> DRAIN. mem_req drops in the same edge.
  - With gnt=0, mem_req and mem_addr hold unchanged.
- Return path: in the cycle after acceptance, mem_rdata[11:4] is written to write bank[ch][idx]. At most one outstanding read.
- DRAIN: one cycle, absorbs the final return write -> SWAP.
- SWAP: toggle display/write bank; pulse frame_done; busy drops at the end of this cycle -> IDLE.
- Latency with gnt held 1: frame_start at cycle 0; requests cycles 1..640; last data cycle 641; SWAP cycle 642 (frame_done=1); new bank visible to reads issued from cycle 643.
- frame_start while busy: ignored (no restart, no queueing); overrun<=1 until reset.
- frame_start in the same cycle as SWAP: counts as busy, so it is ignored and sets overrun.
- Renderer read:
  - rd_sample <= display_bank[rd_ch][rd_idx] on every clock; 1-cycle latency, always available, never stalls.
  - rd_idx>=SAMPLES returns 8'h00.
- Reset mid-fetch (reset low): FSM -> IDLE, mem_req=0 immediately (asynchronous), outstanding return discarded, banks not swapped, overrun cleared.
- Arbiter contract: the arbiter may deassert gnt any cycle; it must not drop an accepted read.

Decomposition:
- Package trace_fetch_pkg:
  - state enum {IDLE,FETCH,DRAIN,SWAP};
  - SAMPLES and channel base constants;
  - SAMPLE_MSB=11, SAMPLE_LSB=4.
- Sub-module trace_sample_ram:
  - 2 banks x 2 channels x SAMPLES x 8 bits;
  - one synchronous write port (bank, ch, idx, data);
  - one registered read port (bank, ch, idx) with out-of-range -> 0.

Test Plan:
- gnt tied 1; memory returns data = addr<<4:
  - addresses seen: 0x559..0x698, then 0x6AD..0x7EC;
  - frame_done at cycle 642;
  - reading ch0 idx0 returns 8'h59 (0x559<<4 -> bits[11:4]=0x59);
  - reading ch1 idx319 returns 8'hEC.
- gnt random ~50%:
  - exactly 640 accepts, no duplicate or skipped addresses;
  - mem_addr stable while req&!gnt;
  - buffer contents identical to the gnt=1 run.
- Read ch0 idx10 continuously during the second fetch: value unchanged until frame_done, new value on the read after the swap.
- frame_start pulsed at cycle 300 of a fetch: fetch completes normally at cycle 642; overrun=1; no second fetch starts.
- reset low at cycle 200 of a fetch:
  - mem_req=0 asynchronously;
  - after release, the display bank still holds the previous frame;
  - a new frame_start gives a full fetch.
- rd_idx=320 and rd_idx=511 -> rd_sample=0; rd_idx=319 -> last sample of the selected channel.
